// File: rtl/mem_sequencer_pkg.sv
// mem_sequencer_pkg: shared state encoding, reset instruction and timer sizing
// for the unified-bus instruction/data sequencer.
package mem_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, FAULT} state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  function automatic int timer_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/mem_sequencer_bus_timer.sv
// bus_timer: counts bus wait cycles; expired fires on the wait cycle that
// brings the count to TimeoutCycles.
module bus_timer
  import mem_sequencer_pkg::*;
#(
  parameter int TimeoutCycles = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = timer_width(TimeoutCycles);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign expired = en && (cnt_q == W'(TimeoutCycles - 1));
endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: multi-cycle fetch/load/store controller sharing one memory bus.
// Optional perf counters cycle_cnt/instret_cnt under MEM_SEQUENCER_PERF_CNT_EN.
module mem_sequencer
  import mem_sequencer_pkg::*;
#(
  parameter int          TimeoutCycles = 255,
  parameter logic [31:0] NopInstr      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        commit,
  output logic        halted,
  output logic        fault,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
`ifdef MEM_SEQUENCER_PERF_CNT_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);
  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d, d_rdata_q, d_rdata_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d, fault_q, fault_d;
  logic        issue, expired;

  bus_timer #(.TimeoutCycles(TimeoutCycles)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (issue),
    .en      (bus_req_q && !bus_ready),
    .expired (expired)
  );

  // The fetch is issued from FETCH itself so it picks up the pc registered on the commit edge.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    d_rdata_d   = d_rdata_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    fault_d     = fault_q;
    issue       = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE:  state_d = run ? FETCH : IDLE;
      FETCH: begin
        if (!bus_req_q) begin
          issue       = 1'b1;
          bus_req_d   = 1'b1;
          bus_addr_d  = pc;
          bus_we_d    = 1'b0;
          bus_wstrb_d = 4'b0000;
        end else if (bus_ready) begin
          bus_req_d = 1'b0;
          instr_d   = bus_rdata;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (mem_read || mem_write) begin
          issue       = 1'b1;
          bus_req_d   = 1'b1;
          bus_addr_d  = d_addr;
          bus_we_d    = mem_write;
          bus_wstrb_d = mem_write ? d_wstrb : 4'b0000;
          bus_wdata_d = d_wdata;
          state_d     = MEM;
        end else begin
          commit  = 1'b1;
          state_d = run ? FETCH : IDLE;
        end
      end
      MEM: begin
        if (bus_ready) begin
          bus_req_d = 1'b0;
          d_rdata_d = bus_we_q ? d_rdata_q : bus_rdata;
          state_d   = WB;
        end
      end
      WB: begin
        commit  = 1'b1;
        state_d = run ? FETCH : IDLE;
      end
      default: state_d = state_q;
    endcase
    if (expired) begin
      bus_req_d = 1'b0;
      fault_d   = 1'b1;
      instr_d   = NopInstr;
      state_d   = FAULT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      instr_q     <= NopInstr;
      d_rdata_q   <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      d_rdata_q   <= d_rdata_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      fault_q     <= fault_d;
    end
  end

  assign instr     = instr_q;
  assign d_rdata   = d_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_addr  = bus_addr_q;
  assign bus_we    = bus_we_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign fault     = fault_q;
  assign halted    = (state_q == IDLE) || (state_q == FAULT);

`ifdef MEM_SEQUENCER_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + 64'(!halted);
    instret_cnt_d = instret_cnt_q + 64'(commit);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif
endmodule
